// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings, field widths and AR state constants
// for the read master and its slot trackers.
package axi_pkg;

  localparam int LEN_W   = 2;
  localparam int AXLEN_W = 4;
  localparam int SIZE_W  = 2;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [LEN_W-1:0] MAX_LEN = 2'd3;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_1B = 2'b00,
    SIZE_2B = 2'b01,
    SIZE_4B = 2'b10
  } size_e;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  // The bus is 32 bits wide, so anything above a 4-byte beat is clamped down.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
    logic [SIZE_W-1:0] r;
    r = (s == 2'b11) ? SIZE_4B : s;
    return r;
  endfunction

endpackage

// File: rtl/rd_slot_tracker.sv
// Outstanding-transaction state for one local read ID: busy flag plus
// remaining beat count, with the expected RLAST and a stray-beat pulse.
module rd_slot_tracker
  import axi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] start_len,
  input  logic             beat,
  input  logic             rlast,
  output logic             busy,
  output logic             exp_last,
  output logic             fwd,
  output logic             err
);

  logic             busy_d, busy_q;
  logic [LEN_W-1:0] left_d, left_q;

  assign busy     = busy_q;
  assign exp_last = (left_q == '0);
  assign fwd      = beat && busy_q;
  assign err      = beat && !busy_q;

  // A slot frees on whichever comes first: RLAST or the final counted beat.
  always_comb begin
    busy_d = busy_q;
    left_d = left_q;
    if (fwd) begin
      if (rlast || exp_last) busy_d = 1'b0;
      else                   left_d = left_q - 1'b1;
    end
    if (start) begin
      busy_d = 1'b1;
      left_d = start_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      left_q <= '0;
    end else begin
      busy_q <= busy_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI read initiator: one AR command in flight at a time, up to two
// outstanding IDs, R beats returned through a one-entry output register.
module axi_read_master
  import axi_pkg::*;
#(
  parameter int BusWidth  = 32,
  parameter int tagbits   = 2,
  parameter int MASTER_ID = 0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_id,
  input  logic [BusWidth-1:0] req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [SIZE_W-1:0]   req_size,
  input  logic [BURST_W-1:0]  req_burst,
  output logic [tagbits-1:0]  ARID,
  output logic [BusWidth-1:0] ARADDR,
  output logic [AXLEN_W-1:0]  ARLEN,
  output logic [SIZE_W-1:0]   ARSIZE,
  output logic [BURST_W-1:0]  ARBURST,
  output logic [1:0]          ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [tagbits-1:0]  RID,
  input  logic [BusWidth-1:0] RDATA,
  input  logic [RESP_W-1:0]   RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic                cl_valid,
  input  logic                cl_ready,
  output logic [BusWidth-1:0] cl_data,
  output logic                cl_id,
  output logic [RESP_W-1:0]   cl_resp,
  output logic                cl_last,
  output logic                proto_err
);

  localparam logic [tagbits-2:0] MID = MASTER_ID[tagbits-2:0];

  ar_state_e           state_q;
  logic                arvalid_q;
  logic [tagbits-1:0]  arid_q;
  logic [BusWidth-1:0] araddr_q;
  logic [LEN_W-1:0]    arlen_q;
  logic [SIZE_W-1:0]   arsize_q;
  logic [BURST_W-1:0]  arburst_q;

  logic [1:0] busy, exp_last, fwd, stray, start, beat;
  logic       req_fire, r_fire, foreign, load, mismatch;

  logic                cl_valid_d, cl_valid_q;
  logic [BusWidth-1:0] cl_data_d, cl_data_q;
  logic                cl_id_d, cl_id_q;
  logic [RESP_W-1:0]   cl_resp_d, cl_resp_q;
  logic                cl_last_d, cl_last_q;
  logic                proto_err_d, proto_err_q;

  // Gated by ARESET so neither handshake can be offered while in reset.
  assign req_ready = !ARESET && (state_q == AR_IDLE) && !busy[req_id];
  assign RREADY    = !ARESET && (!cl_valid_q || cl_ready);
  assign req_fire  = req_valid && req_ready;
  assign r_fire    = RVALID && RREADY;
  assign foreign   = (RID[tagbits-1:1] != MID);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= AR_IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      case (state_q)
        AR_IDLE: if (req_fire) begin
          state_q   <= AR_SEND;
          arvalid_q <= 1'b1;
          arid_q    <= {MID, req_id};
          araddr_q  <= req_addr;
          arlen_q   <= req_len;
          arsize_q  <= clamp_size(req_size);
          arburst_q <= req_burst;
        end
        AR_SEND: if (ARREADY) begin
          state_q   <= AR_IDLE;
          arvalid_q <= 1'b0;
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

  assign ARVALID = arvalid_q;
  assign ARID    = arid_q;
  assign ARADDR  = araddr_q;
  assign ARLEN   = {2'b00, arlen_q};
  assign ARSIZE  = arsize_q;
  assign ARBURST = arburst_q;
  assign ARLOCK  = '0;
  assign ARCACHE = '0;
  assign ARPROT  = '0;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign start[g] = req_fire && (req_id == 1'(g));
    assign beat[g]  = r_fire && !foreign && (RID[0] == 1'(g));

    rd_slot_tracker u_trk (
      .clk       (ACLK),
      .rst       (ARESET),
      .start     (start[g]),
      .start_len (req_len),
      .beat      (beat[g]),
      .rlast     (RLAST),
      .busy      (busy[g]),
      .exp_last  (exp_last[g]),
      .fwd       (fwd[g]),
      .err       (stray[g])
    );
  end

  assign load     = |fwd;
  assign mismatch = |(fwd & {2{RLAST}} ^ fwd & exp_last);

  always_comb begin
    cl_valid_d  = cl_valid_q;
    cl_data_d   = cl_data_q;
    cl_id_d     = cl_id_q;
    cl_resp_d   = cl_resp_q;
    cl_last_d   = cl_last_q;
    if (load) begin
      cl_valid_d = 1'b1;
      cl_data_d  = RDATA;
      cl_id_d    = RID[0];
      cl_resp_d  = RRESP;
      cl_last_d  = RLAST;
    end else if (cl_ready) begin
      cl_valid_d = 1'b0;
    end
    proto_err_d = proto_err_q | (|stray) | mismatch | (r_fire && foreign);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cl_valid_q  <= 1'b0;
      cl_data_q   <= '0;
      cl_id_q     <= 1'b0;
      cl_resp_q   <= '0;
      cl_last_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cl_valid_q  <= cl_valid_d;
      cl_data_q   <= cl_data_d;
      cl_id_q     <= cl_id_d;
      cl_resp_q   <= cl_resp_d;
      cl_last_q   <= cl_last_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cl_valid  = cl_valid_q;
  assign cl_data   = cl_data_q;
  assign cl_id     = cl_id_q;
  assign cl_resp   = cl_resp_q;
  assign cl_last   = cl_last_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: AR issue, R return, backpressure,
// interleaving, protocol errors and reset during a burst.
module tb_axi_read_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready, req_id;
  logic [31:0] req_addr;
  logic [1:0]  req_len, req_size, req_burst;
  logic [1:0]  ARID, ARSIZE, ARBURST, ARLOCK;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN, ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [1:0]  RID, RRESP;
  logic [31:0] RDATA;
  logic        RLAST, RVALID, RREADY;
  logic        cl_valid, cl_ready, cl_id, cl_last, proto_err;
  logic [31:0] cl_data;
  logic [1:0]  cl_resp;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axi_read_master #(.BusWidth(32), .tagbits(2), .MASTER_ID(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_data(cl_data), .cl_id(cl_id),
    .cl_resp(cl_resp), .cl_last(cl_last), .proto_err(proto_err)
  );

  // Request accept plus AR handshake; relies on ARREADY already being high.
  task automatic issue(input logic id, input logic [31:0] addr, input logic [1:0] len);
    @(negedge ACLK);
    req_valid = 1'b1; req_id = id; req_addr = addr; req_len = len;
    req_size = 2'b10; req_burst = 2'b01;
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; req_valid = 1'b1; req_id = 1'b0; req_addr = '0; req_len = '0;
    req_size = '0; req_burst = '0; ARREADY = 1'b1; RID = '0; RDATA = '0; RRESP = '0;
    RLAST = 1'b0; RVALID = 1'b0; cl_ready = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    tests++; if (ARVALID !== 1'b0) begin fails++; $display("FAIL rst_arvalid: got %b want 0", ARVALID); end
    tests++; if (RREADY !== 1'b0) begin fails++; $display("FAIL rst_rready: got %b want 0", RREADY); end
    tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL rst_cl_valid: got %b want 0", cl_valid); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
    tests++; if (ARADDR !== 32'h0) begin fails++; $display("FAIL rst_araddr: got %h want 0", ARADDR); end
    req_valid = 1'b0;
    ARESET = 1'b0;
  endtask

  task automatic test_single;
    @(negedge ACLK);
    req_valid = 1'b1; req_id = 1'b0; req_addr = 32'h10; req_len = 2'd0;
    req_size = 2'b10; req_burst = 2'b01; ARREADY = 1'b1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL single_req_ready: got %b want 1", req_ready); end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    tests++; if (ARVALID !== 1'b1) begin fails++; $display("FAIL single_arvalid: got %b want 1", ARVALID); end
    tests++; if (ARID !== 2'b00) begin fails++; $display("FAIL single_arid: got %b want 00", ARID); end
    tests++; if (ARLEN !== 4'd0) begin fails++; $display("FAIL single_arlen: got %h want 0", ARLEN); end
    tests++; if (ARADDR !== 32'h10) begin fails++; $display("FAIL single_araddr: got %h want 10", ARADDR); end
    tests++; if (ARSIZE !== 2'b10 || ARBURST !== 2'b01) begin fails++; $display("FAIL single_size_burst: got %b/%b want 10/01", ARSIZE, ARBURST); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL single_send_req_ready: got %b want 0", req_ready); end
    @(posedge ACLK); #1;
    tests++; if (ARVALID !== 1'b0) begin fails++; $display("FAIL single_arvalid_drop: got %b want 0", ARVALID); end
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b00; RDATA = 32'hDEADBEEF; RLAST = 1'b1; RRESP = 2'b00;
    tests++; if (RREADY !== 1'b1) begin fails++; $display("FAIL single_rready: got %b want 1", RREADY); end
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL single_cl_valid: got %b want 1", cl_valid); end
    tests++; if (cl_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_cl_data: got %h want deadbeef", cl_data); end
    tests++; if (cl_last !== 1'b1) begin fails++; $display("FAIL single_cl_last: got %b want 1", cl_last); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL single_proto_err: got %b want 0", proto_err); end
    @(posedge ACLK); #1;
    tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL single_cl_drain: got %b want 0", cl_valid); end
  endtask

  task automatic test_backpressure;
    issue(1'b0, 32'h100, 2'd3);
    cl_ready = 1'b0;
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b00; RDATA = 32'hA0; RLAST = 1'b0;
    @(posedge ACLK); #1;
    RDATA = 32'hA1;
    tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL bp_cl_valid: got %b want 1", cl_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      tests++; if (RREADY !== 1'b0) begin fails++; $display("FAIL bp_rready_low[%0d]: got %b want 0", i, RREADY); end
      tests++; if (cl_data !== 32'hA0) begin fails++; $display("FAIL bp_hold[%0d]: got %h want a0", i, cl_data); end
    end
    @(negedge ACLK);
    cl_ready = 1'b1;
    @(posedge ACLK); #1;
    tests++; if (cl_data !== 32'hA1 || cl_valid !== 1'b1) begin fails++; $display("FAIL bp_beat1: got %h/%b want a1/1", cl_data, cl_valid); end
    RDATA = 32'hA2;
    @(posedge ACLK); #1;
    tests++; if (cl_data !== 32'hA2) begin fails++; $display("FAIL bp_beat2: got %h want a2", cl_data); end
    RDATA = 32'hA3; RLAST = 1'b1;
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (cl_data !== 32'hA3 || cl_last !== 1'b1) begin fails++; $display("FAIL bp_beat3: got %h/%b want a3/1", cl_data, cl_last); end
    @(posedge ACLK); #1;
    req_id = 1'b0;
    tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", cl_valid); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL bp_proto_err: got %b want 0", proto_err); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_slot_free: got %b want 1", req_ready); end
  endtask

  task automatic test_two_outstanding;
    issue(1'b0, 32'h200, 2'd1);
    issue(1'b1, 32'h300, 2'd0);
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b01; RDATA = 32'hB0; RLAST = 1'b1; req_id = 1'b1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL two_id1_busy: got %b want 0", req_ready); end
    @(posedge ACLK); #1;
    tests++; if (cl_data !== 32'hB0 || cl_id !== 1'b1 || cl_last !== 1'b1) begin fails++; $display("FAIL two_b0: got %h/%b/%b want b0/1/1", cl_data, cl_id, cl_last); end
    RID = 2'b00; RDATA = 32'hC0; RLAST = 1'b0;
    @(negedge ACLK);
    req_valid = 1'b1; req_id = 1'b1; req_addr = 32'h400; req_len = 2'd0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL two_id1_reopen: got %b want 1", req_ready); end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    tests++; if (cl_data !== 32'hC0 || cl_id !== 1'b0 || cl_last !== 1'b0) begin fails++; $display("FAIL two_c0: got %h/%b/%b want c0/0/0", cl_data, cl_id, cl_last); end
    tests++; if (ARVALID !== 1'b1 || ARID !== 2'b01 || ARADDR !== 32'h400) begin fails++; $display("FAIL two_ar_id1: got %b/%b/%h want 1/01/400", ARVALID, ARID, ARADDR); end
    RDATA = 32'hC1; RLAST = 1'b1;
    @(posedge ACLK); #1;
    tests++; if (cl_data !== 32'hC1 || cl_last !== 1'b1) begin fails++; $display("FAIL two_c1: got %h/%b want c1/1", cl_data, cl_last); end
    tests++; if (ARVALID !== 1'b0) begin fails++; $display("FAIL two_ar_done: got %b want 0", ARVALID); end
    RID = 2'b01; RDATA = 32'hB1; RLAST = 1'b1;
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (cl_data !== 32'hB1 || cl_id !== 1'b1) begin fails++; $display("FAIL two_b1: got %h/%b want b1/1", cl_data, cl_id); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL two_proto_err: got %b want 0", proto_err); end
    @(posedge ACLK); #1;
  endtask

  task automatic test_ar_stall;
    ARREADY = 1'b0;
    @(negedge ACLK);
    req_valid = 1'b1; req_id = 1'b0; req_addr = 32'h500; req_len = 2'd3;
    req_size = 2'b11; req_burst = 2'b10;
    @(posedge ACLK); #1;
    req_valid = 1'b0; req_id = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      tests++; if (ARVALID !== 1'b1) begin fails++; $display("FAIL stall_arvalid[%0d]: got %b want 1", i, ARVALID); end
      tests++; if (ARADDR !== 32'h500 || ARLEN !== 4'd3 || ARSIZE !== 2'b10 || ARBURST !== 2'b10) begin fails++; $display("FAIL stall_fields[%0d]: got %h/%h/%b/%b want 500/3/10/10", i, ARADDR, ARLEN, ARSIZE, ARBURST); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    ARREADY = 1'b1;
    @(posedge ACLK); #1;
    tests++; if (ARVALID !== 1'b0) begin fails++; $display("FAIL stall_release: got %b want 0", ARVALID); end
  endtask

  task automatic test_errors;
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b00; RDATA = 32'hE1; RLAST = 1'b0;
    @(posedge ACLK); #1;
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL err_beat1_clean: got %b want 0", proto_err); end
    RDATA = 32'hE2; RLAST = 1'b1;
    @(posedge ACLK); #1;
    RVALID = 1'b0; req_id = 1'b0;
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL err_early_last: got %b want 1", proto_err); end
    tests++; if (cl_data !== 32'hE2 || cl_last !== 1'b1) begin fails++; $display("FAIL err_early_fwd: got %h/%b want e2/1", cl_data, cl_last); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL err_slot_freed: got %b want 1", req_ready); end
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b01; RDATA = 32'hF1; RLAST = 1'b1;
    tests++; if (RREADY !== 1'b1) begin fails++; $display("FAIL err_stray_rready: got %b want 1", RREADY); end
    @(posedge ACLK); #1;
    RID = 2'b10; RDATA = 32'hF2;
    tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL err_stray_dropped: got %b want 0", cl_valid); end
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (cl_valid !== 1'b0 || cl_data !== 32'hE2) begin fails++; $display("FAIL err_foreign_dropped: got %b/%h want 0/e2", cl_valid, cl_data); end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 32'h600, 2'd3);
    cl_ready = 1'b0;
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b00; RDATA = 32'h60; RLAST = 1'b0;
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL rm_pending: got %b want 1", cl_valid); end
    @(negedge ACLK);
    ARESET = 1'b1; req_id = 1'b0;
    #1;
    tests++; if (cl_valid !== 1'b0 || cl_data !== 32'h0) begin fails++; $display("FAIL rm_cl_cleared: got %b/%h want 0/0", cl_valid, cl_data); end
    tests++; if (proto_err !== 1'b0 || ARVALID !== 1'b0) begin fails++; $display("FAIL rm_flags: got %b/%b want 0/0", proto_err, ARVALID); end
    tests++; if (RREADY !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rm_readies: got %b/%b want 0/0", RREADY, req_ready); end
    @(negedge ACLK);
    ARESET = 1'b0; cl_ready = 1'b1;
    @(negedge ACLK);
    RVALID = 1'b1; RID = 2'b00; RDATA = 32'h61; RLAST = 1'b0;
    @(posedge ACLK); #1;
    RVALID = 1'b0;
    tests++; if (proto_err !== 1'b1 || cl_valid !== 1'b0) begin fails++; $display("FAIL rm_late_beat: got %b/%b want 1/0", proto_err, cl_valid); end
    @(negedge ACLK);
    req_valid = 1'b1; req_id = 1'b0; req_addr = 32'h700; req_len = 2'd0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_req_after: got %b want 1", req_ready); end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    tests++; if (ARVALID !== 1'b1 || ARADDR !== 32'h700) begin fails++; $display("FAIL rm_ar_after: got %b/%h want 1/700", ARVALID, ARADDR); end
    @(posedge ACLK); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_two_outstanding();
    test_ar_stall();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
